rec_nibble_serializer: RTL and testbench

Stage directly downstream of the packed-record producer. It accepts one packed record per valid/ready handshake and emits it as a stream of 4-bit beats: a header beat, then the `y` elements, then the `z` elements. The `z` elements are walked in declared index order from `$left` to `$right` on each dimension. Each beat carries its kind and its real SystemVerilog indices, so the consumer never re-derives the packed-array geometry.

---
 rtl/rec_pkg.sv | 50 +++++
 rtl/rec_nibble_serializer.sv | 141 ++++++++++++++
 tb/tb_rec_nibble_serializer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rec_pkg.sv
// Shared record layout for the packed-record stream and its nibble serializer.
// All geometry constants are derived from the typedefs so a layout change propagates.
package rec_pkg;

    typedef logic [2:7][3:0]        y_arr_t;
    typedef logic [7:2][2:9][1:4]   z_arr_t;

    typedef struct packed {
        y_arr_t y;
    } sy_t;

    // z2 is a flat alias of the same bits; only the z view defines beat order
    typedef union packed {
        z_arr_t                     z;
        logic [$bits(z_arr_t)-1:0]  z2;
    } sz_u;

    typedef struct packed {
        logic       t;
        logic [5:2] x;
        sy_t        sy;
        sz_u        sz;
    } rec_t;

    typedef enum logic [1:0] {
        KIND_HDR = 2'd0,
        KIND_Y   = 2'd1,
        KIND_Z   = 2'd2
    } beat_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_Y,
        ST_Z
    } ser_state_e;

    localparam int REC_W   = $bits(rec_t);
    localparam int Y_BEATS = $size(y_arr_t, 1);
    localparam int Z_BEATS = $size(z_arr_t, 1) * $size(z_arr_t, 2);
    localparam int BEATS   = 1 + Y_BEATS + Z_BEATS;

    localparam logic [3:0] Y_FIRST  = 4'($left(y_arr_t, 1));
    localparam logic [3:0] Y_LAST   = 4'($right(y_arr_t, 1));
    localparam logic [3:0] ZI_FIRST = 4'($left(z_arr_t, 1));
    localparam logic [3:0] ZI_LAST  = 4'($right(z_arr_t, 1));
    localparam logic [3:0] ZJ_FIRST = 4'($left(z_arr_t, 2));
    localparam logic [3:0] ZJ_LAST  = 4'($right(z_arr_t, 2));

endpackage

// File: rtl/rec_nibble_serializer.sv
// Serializes one packed rec_t into 4-bit beats: header, y elements, then z elements,
// each tagged with its kind and real array indices.
module rec_nibble_serializer
    import rec_pkg::*;
#(
    parameter int SKIP_Z = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REC_W-1:0] in_rec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [1:0]       out_kind,
    output logic             out_t,
    output logic [3:0]       out_i,
    output logic [3:0]       out_j,
    output logic             out_last
);

    ser_state_e        state_q, state_d;
    logic [5:0]        k_q, k_d;
    logic [3:0]        i_q, i_d;
    logic [3:0]        j_q, j_d;
    logic [REC_W-1:0]  hold_q;
    logic              fire;
    logic              accept;
    logic              finish;

    // Beat order is MSB-first nibble order below t, so one indexed select covers every beat
    logic [BEATS-1:0][3:0] nibs;
    assign nibs = hold_q[REC_W-2:0];

    assign out_valid = (state_q != ST_IDLE);
    assign fire      = out_valid && out_ready;
    assign out_last  = ((state_q == ST_Z) && (i_q == ZI_LAST) && (j_q == ZJ_LAST)) ||
                       ((SKIP_Z != 0) && (state_q == ST_Y) && (i_q == Y_LAST));
    assign in_ready  = (state_q == ST_IDLE) || (out_last && fire);
    assign accept    = in_valid && in_ready;

    assign out_data  = out_valid ? nibs[6'(BEATS - 1) - k_q] : 4'd0;
    assign out_t     = (state_q == ST_HDR) ? hold_q[REC_W-1] : 1'b0;
    assign out_i     = ((state_q == ST_Y) || (state_q == ST_Z)) ? i_q : 4'd0;
    assign out_j     = (state_q == ST_Z) ? j_q : 4'd0;

    always_comb begin
        out_kind = KIND_HDR;
        unique case (state_q)
            ST_Y:    out_kind = KIND_Y;
            ST_Z:    out_kind = KIND_Z;
            default: out_kind = KIND_HDR;
        endcase
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        finish  = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = state_q;
            ST_HDR: begin
                if (fire) begin
                    state_d = ST_Y;
                    k_d     = k_q + 6'd1;
                    i_d     = Y_FIRST;
                end
            end
            ST_Y: begin
                if (fire) begin
                    if (i_q == Y_LAST) begin
                        if (SKIP_Z != 0) begin
                            finish = 1'b1;
                        end else begin
                            state_d = ST_Z;
                            k_d     = k_q + 6'd1;
                            i_d     = ZI_FIRST;
                            j_d     = ZJ_FIRST;
                        end
                    end else begin
                        k_d = k_q + 6'd1;
                        i_d = i_q + 4'd1;
                    end
                end
            end
            ST_Z: begin
                if (fire) begin
                    if (out_last) begin
                        finish = 1'b1;
                    end else if (j_q == ZJ_LAST) begin
                        k_d = k_q + 6'd1;
                        j_d = ZJ_FIRST;
                        i_d = i_q - 4'd1;
                    end else begin
                        k_d = k_q + 6'd1;
                        j_d = j_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (finish) begin
            state_d = ST_IDLE;
            k_d     = 6'd0;
            i_d     = 4'd0;
            j_d     = 4'd0;
        end
        // A new record may be taken on the last beat of the previous one
        if (accept) begin
            state_d = ST_HDR;
            k_d     = 6'd0;
            i_d     = 4'd0;
            j_d     = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= 6'd0;
            i_q     <= 4'd0;
            j_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    // Holding register is data only; it is frozen except on an input handshake
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_q <= in_rec;
        end
    end

endmodule

// File: tb/tb_rec_nibble_serializer.sv
// Bench for rec_nibble_serializer: directed vectors, randomized records with backpressure,
// back-to-back records, SKIP_Z variant and mid-record reset, against a field-level model.
module tb_rec_nibble_serializer;
    import rec_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, s_in_valid;
    logic             in_ready, s_in_ready;
    logic [REC_W-1:0] in_rec;
    logic             out_ready;
    logic             out_valid, s_out_valid;
    logic [3:0]       out_data, s_out_data;
    logic [1:0]       out_kind, s_out_kind;
    logic             out_t, s_out_t;
    logic [3:0]       out_i, s_out_i;
    logic [3:0]       out_j, s_out_j;
    logic             out_last, s_out_last;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];
    logic [16:0] obs_log[$];

    typedef struct {
        string       name;
        int          beat;
        logic [16:0] exp;
    } spot_t;

    always #5 clk = ~clk;

    rec_nibble_serializer #(.SKIP_Z(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rec(in_rec),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_kind(out_kind),
        .out_t(out_t), .out_i(out_i), .out_j(out_j), .out_last(out_last)
    );

    rec_nibble_serializer #(.SKIP_Z(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_rec(in_rec),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_kind(s_out_kind),
        .out_t(s_out_t), .out_i(s_out_i), .out_j(s_out_j), .out_last(s_out_last)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [16:0] pk(input logic v, input logic [1:0] k, input logic t,
                                       input logic [3:0] i, input logic [3:0] j,
                                       input logic [3:0] d, input logic l);
        return {v, k, t, i, j, d, l};
    endfunction

    function automatic logic [16:0] obs(input bit s);
        if (s) return {s_out_valid, s_out_kind, s_out_t, s_out_i, s_out_j, s_out_data, s_out_last};
        return {out_valid, out_kind, out_t, out_i, out_j, out_data, out_last};
    endfunction

    function automatic logic in_rdy(input bit s);
        return s ? s_in_ready : in_ready;
    endfunction

    function automatic rec_t rand_rec();
        logic [223:0] tmp;
        tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return rec_t'(tmp[220:0]);
    endfunction

    function automatic rec_t dir_rec();
        rec_t r;
        r.t = 1'b1;
        r.x = 4'hA;
        for (int i = 2; i <= 7; i++) r.sy.y[i] = 4'(i);
        for (int i = 7; i >= 2; i--)
            for (int j = 2; j <= 9; j++) r.sz.z[i][j] = 4'((i + j) & 15);
        return r;
    endfunction

    // Reference: walk the record fields in declared index order
    function automatic void model(input rec_t r, input bit skip);
        exp_q.push_back(pk(1'b1, 2'd0, r.t, 4'd0, 4'd0, r.x, 1'b0));
        for (int i = 2; i <= 7; i++)
            exp_q.push_back(pk(1'b1, 2'd1, 1'b0, 4'(i), 4'd0, r.sy.y[i], skip && (i == 7)));
        if (!skip)
            for (int i = 7; i >= 2; i--)
                for (int j = 2; j <= 9; j++)
                    exp_q.push_back(pk(1'b1, 2'd2, 1'b0, 4'(i), 4'(j), r.sz.z[i][j],
                                       (i == 2) && (j == 9)));
    endfunction

    task automatic set_ready(input int duty);
        out_ready = ($urandom_range(0, 99) < duty);
    endtask

    task automatic offer(input rec_t r, input bit s, input string tag);
        int n = 0;
        in_rec = r;
        if (s) s_in_valid = 1'b1; else in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_rdy(s) && n < 200);
        if (!in_rdy(s)) chk({tag, " accept_timeout"}, 32'(in_rdy(s)), 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        in_rec     = rand_rec();
    endtask

    task automatic collect(input int duty, input bit s, input string tag);
        int          cyc = 0;
        bit          stalled = 1'b0;
        logic [16:0] prev = '0;
        logic [16:0] cur;
        logic [16:0] e;
        obs_log.delete();
        set_ready(duty);
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            cur = obs(s);
            if (stalled) chk({tag, " stall_hold"}, 32'(cur), 32'(prev));
            if (!cur[16]) begin
                chk({tag, " out_valid"}, 32'(cur[16]), 32'd1);
                cyc = 3000;
            end else if (out_ready) begin
                e = exp_q.pop_front();
                obs_log.push_back(cur);
                chk({tag, " beat"}, 32'(cur), 32'(e));
                chk({tag, " in_ready"}, 32'(in_rdy(s)), 32'(e[0]));
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev    = cur;
            end
            @(posedge clk);
            #1;
            set_ready(duty);
            in_rec = rand_rec();
        end
        if (exp_q.size() > 0) begin
            chk({tag, " beats_missing"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        spot_t  spots[6];
        spot_t  sk_spots[2];
        rec_t   ra, rb;
        logic [16:0] e;

        spots[0] = '{"dir_b0_hdr",  0,  pk(1'b1, 2'd0, 1'b1, 4'd0, 4'd0, 4'hA, 1'b0)};
        spots[1] = '{"dir_b1_y2",   1,  pk(1'b1, 2'd1, 1'b0, 4'd2, 4'd0, 4'h2, 1'b0)};
        spots[2] = '{"dir_b6_y7",   6,  pk(1'b1, 2'd1, 1'b0, 4'd7, 4'd0, 4'h7, 1'b0)};
        spots[3] = '{"dir_b7_z72",  7,  pk(1'b1, 2'd2, 1'b0, 4'd7, 4'd2, 4'h9, 1'b0)};
        spots[4] = '{"dir_b15_z62", 15, pk(1'b1, 2'd2, 1'b0, 4'd6, 4'd2, 4'h8, 1'b0)};
        spots[5] = '{"dir_b54_z29", 54, pk(1'b1, 2'd2, 1'b0, 4'd2, 4'd9, 4'hB, 1'b1)};
        sk_spots[0] = '{"skz_b0_hdr", 0, pk(1'b1, 2'd0, 1'b1, 4'd0, 4'd0, 4'hA, 1'b0)};
        sk_spots[1] = '{"skz_b6_y7",  6, pk(1'b1, 2'd1, 1'b0, 4'd7, 4'd0, 4'h7, 1'b1)};

        // Reset held with a record offered
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        s_in_valid = 1'b0;
        in_rec     = dir_rec();
        out_ready  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst out_valid", 32'(out_valid), 32'd0);
            chk("rst out_last", 32'(out_last), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle in_ready", 32'(in_ready), 32'd1);
        chk("idle outputs", 32'(obs(1'b0)), 32'd0);
        chk("idle s_outputs", 32'(obs(1'b1)), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_rec   = rand_rec();

        // Directed record, always ready
        model(dir_rec(), 1'b0);
        collect(100, 1'b0, "dir");
        chk("dir beat_count", 32'(obs_log.size()), 32'd55);
        for (int n = 0; n < 6; n++)
            if (obs_log.size() > spots[n].beat)
                chk(spots[n].name, 32'(obs_log[spots[n].beat]), 32'(spots[n].exp));
        @(negedge clk);
        chk("dir idle_after", 32'(out_valid), 32'd0);

        // Random records under 30% ready backpressure
        for (int r = 0; r < 3; r++) begin
            ra = rand_rec();
            model(ra, 1'b0);
            offer(ra, 1'b0, "bp");
            collect(30, 1'b0, "bp");
            chk("bp beat_count", 32'(obs_log.size()), 32'd55);
        end

        // Back-to-back records, second offered while the first streams
        ra = rand_rec();
        rb = rand_rec();
        model(ra, 1'b0);
        model(rb, 1'b0);
        out_ready = 1'b1;
        in_rec    = ra;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("b2b first_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_rec = rb;
        for (int b = 0; b < 110; b++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk("b2b beat", 32'(obs(1'b0)), 32'(e));
            if (b < 55) chk("b2b in_ready_pulse", 32'(in_ready), 32'(e[0]));
            @(posedge clk);
            #1;
            if (b == 54) begin
                in_valid = 1'b0;
                in_rec   = rand_rec();
            end
        end
        @(negedge clk);
        chk("b2b idle_after", 32'(out_valid), 32'd0);

        // SKIP_Z variant
        model(dir_rec(), 1'b1);
        offer(dir_rec(), 1'b1, "skz");
        collect(100, 1'b1, "skz");
        chk("skz beat_count", 32'(obs_log.size()), 32'd7);
        for (int n = 0; n < 2; n++)
            if (obs_log.size() > sk_spots[n].beat)
                chk(sk_spots[n].name, 32'(obs_log[sk_spots[n].beat]), 32'(sk_spots[n].exp));
        foreach (obs_log[n]) chk("skz no_z_kind", 32'(obs_log[n][15:14] == 2'd2), 32'd0);
        @(negedge clk);
        chk("skz idle_after", 32'(s_out_valid), 32'd0);

        // Reset during z[5][4]
        out_ready = 1'b1;
        offer(dir_rec(), 1'b0, "mid");
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("mid z54_beat", 32'(obs(1'b0)), 32'(pk(1'b1, 2'd2, 1'b0, 4'd5, 4'd4, 4'h9, 1'b0)));
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid released idle", 32'(obs(1'b0)), 32'd0);
        chk("mid released in_ready", 32'(in_ready), 32'd1);
        ra = rand_rec();
        model(ra, 1'b0);
        offer(ra, 1'b0, "post");
        collect(100, 1'b0, "post");
        chk("post beat_count", 32'(obs_log.size()), 32'd55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
